// File: rtl/fetch_unit.sv
// fetch_unit: PC generation, imem read issue, prefetch FIFO and branch redirect.
// Optional macro FETCH_BYPASS_EN: live response bypasses an empty FIFO to decode.
//
// Ports:
//   clk_i, rst_ni          clock, async active-low reset
//   fetch_en_i             permit new reads (IDLE/RUN)
//   imem_addr_o/ren_o      word-aligned read request, combinational
//   imem_data_i            read data, one cycle after request
//   branch_i/target_i      single-cycle redirect
//   instr_o/pc_o/valid_o   decode side, handshake with instr_ready_i
//   misaligned_o           target had nonzero low bits (combinational)
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        fetch_en_i,
    output logic [31:0] imem_addr_o,
    output logic        imem_ren_o,
    input  logic [31:0] imem_data_i,
    input  logic        branch_i,
    input  logic [31:0] branch_target_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic        misaligned_o
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic          inflight_q, inflight_d;
    logic [31:0]   inflight_pc_q, inflight_pc_d;
    logic [31:0]   fifo_data_q [FIFO_DEPTH];
    logic [31:0]   fifo_pc_q   [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CW-1:0] count_q, count_d;

    logic [31:0] target;
    logic [CW:0] occ;
    logic        fifo_empty;
    logic        rsp_live;
    logic        push;
    logic        pop;
    logic        fifo_pop;
    logic        room;
    logic        issue;

    assign target     = {branch_target_i[31:2], 2'b00};
    assign fifo_empty = (count_q == '0);
    // A redirect kills whatever response is arriving this cycle.
    assign rsp_live   = inflight_q & ~branch_i;
    assign pop        = instr_valid_o & instr_ready_i;

`ifdef FETCH_BYPASS_EN
    logic byp;
    assign byp           = fifo_empty & rsp_live;
    assign instr_valid_o = ~branch_i & (~fifo_empty | byp);
    assign instr_o       = byp ? imem_data_i   : fifo_data_q[rd_ptr_q];
    assign instr_pc_o    = byp ? inflight_pc_q : fifo_pc_q[rd_ptr_q];
    assign push          = rsp_live & ~(byp & instr_ready_i);
    assign fifo_pop      = pop & ~fifo_empty;
`else
    assign instr_valid_o = ~branch_i & ~fifo_empty;
    assign instr_o       = fifo_data_q[rd_ptr_q];
    assign instr_pc_o    = fifo_pc_q[rd_ptr_q];
    assign push          = rsp_live;
    assign fifo_pop      = pop;
`endif

    // Entries held plus the one in flight, less what leaves this cycle.
    // A pop always has a FIFO entry or a live response behind it.
    assign occ  = {1'b0, count_q}
                + {{CW{1'b0}}, inflight_q}
                - {{CW{1'b0}}, pop};
    assign room = occ < (CW + 1)'(FIFO_DEPTH);

    assign issue        = branch_i | ((state_q == S_RUN) & room);
    assign imem_ren_o   = issue;
    assign imem_addr_o  = branch_i ? target : pc_q;
    assign misaligned_o = branch_i & (|branch_target_i[1:0]);

    always_comb begin
        state_d       = fetch_en_i ? S_RUN : S_IDLE;
        pc_d          = pc_q;
        inflight_d    = issue;
        inflight_pc_d = inflight_pc_q;
        count_d       = count_q + CW'(push) - CW'(fifo_pop);
        if (issue) begin
            pc_d          = imem_addr_o + 32'd4;
            inflight_pc_d = imem_addr_o;
        end
        if (branch_i) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data_q[i] <= '0;
                fifo_pc_q[i]   <= '0;
            end
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            count_q       <= count_d;
            if (push) begin
                fifo_data_q[wr_ptr_q] <= imem_data_i;
                fifo_pc_q[wr_ptr_q]   <= inflight_pc_q;
            end
            if (branch_i) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
            end else begin
                rd_ptr_q <= rd_ptr_q + PW'(fifo_pop);
                wr_ptr_q <= wr_ptr_q + PW'(push);
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: random + directed stimulus against a queue-based
// model of issued reads, delivery order, latency and the room limit.
module tb_fetch_unit;

    localparam int DEPTH = 2;
`ifdef FETCH_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        fetch_en = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_ren;
    logic [31:0] imem_data = '0;
    logic        branch = 1'b0;
    logic [31:0] branch_target = '0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        misaligned;

    fetch_unit #(
        .RESET_PC   (32'h0),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .fetch_en_i      (fetch_en),
        .imem_addr_o     (imem_addr),
        .imem_ren_o      (imem_ren),
        .imem_data_i     (imem_data),
        .branch_i        (branch),
        .branch_target_i (branch_target),
        .instr_o         (instr),
        .instr_pc_o      (instr_pc),
        .instr_valid_o   (instr_valid),
        .instr_ready_i   (instr_ready),
        .misaligned_o    (misaligned)
    );

    always #5 clk = ~clk;

    // Memory: word at byte address 4k holds k; garbage when not read.
    always @(posedge clk)
        imem_data <= imem_ren ? (imem_addr >> 2) : $urandom;

    typedef struct {
        int unsigned cyc;
        logic [31:0] addr;
    } ent_t;

    ent_t        q[$];
    int unsigned now = 0;
    logic [31:0] issue_pc = '0;
    logic        prev_en = 1'b0;
    int          n_tests = 0;
    int          n_fail = 0;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0d: got %h expected %h",
                     tag, now, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        issue_pc = '0;
        prev_en  = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        branch = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_pc", instr_pc, 32'd0);
        chk("rst_ren", {31'b0, imem_ren}, 32'd0);
        chk("rst_mis", {31'b0, misaligned}, 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        model_reset();
    endtask

    task automatic step(input logic en, input logic rdy,
                        input logic br, input logic [31:0] tgt);
        logic        ev;
        logic        epop;
        logic        eren;
        int          occ;
        logic [31:0] t;
        @(negedge clk);
        fetch_en      = en;
        instr_ready   = rdy;
        branch        = br;
        branch_target = tgt;
        #1;
        t    = {tgt[31:2], 2'b00};
        ev   = !br && q.size() > 0 && (q[0].cyc + LAT <= now);
        epop = ev && rdy;
        occ  = q.size() - (epop ? 1 : 0);
        eren = br || (prev_en && occ < DEPTH);
        chk("valid", {31'b0, instr_valid}, {31'b0, ev});
        chk("ren", {31'b0, imem_ren}, {31'b0, eren});
        chk("misaligned", {31'b0, misaligned},
            {31'b0, br && (tgt[1:0] != 2'b00)});
        if (ev) begin
            chk("instr_pc", instr_pc, q[0].addr);
            chk("instr", instr, q[0].addr >> 2);
        end
        if (eren)
            chk("imem_addr", imem_addr, br ? t : issue_pc);
        if (epop)
            void'(q.pop_front());
        if (br) begin
            q.delete();
            q.push_back('{now, t});
            issue_pc = t + 32'd4;
        end else if (eren) begin
            q.push_back('{now, issue_pc});
            issue_pc = issue_pc + 32'd4;
        end
        prev_en = en;
        now++;
    endtask

    initial begin
        do_reset();
        repeat (20) step(1'b1, 1'b1, 1'b0, '0);
        repeat (6)  step(1'b1, 1'b0, 1'b0, '0);
        step(1'b1, 1'b0, 1'b1, 32'h100);
        repeat (6)  step(1'b1, 1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 1'b1, 32'h203);
        repeat (4)  step(1'b1, 1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF4);
        repeat (6)  step(1'b1, 1'b1, 1'b0, '0);
        repeat (5)  step(1'b0, 1'b1, 1'b0, '0);
        repeat (5)  step(1'b1, 1'b1, 1'b0, '0);
        do_reset();
        repeat (8)  step(1'b1, 1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 1'b1, 32'h40);
        step(1'b1, 1'b1, 1'b1, 32'h80);
        repeat (4)  step(1'b1, 1'b1, 1'b0, '0);

        for (int i = 0; i < 3000; i++) begin
            logic        en;
            logic        rdy;
            logic        br;
            logic [31:0] tgt;
            en  = ($urandom_range(0, 9) != 0);
            rdy = ($urandom_range(0, 2) != 0);
            br  = ($urandom_range(0, 11) == 0);
            tgt = $urandom;
            if ($urandom_range(0, 1) == 0)
                tgt[31:12] = '0;
            if ($urandom_range(0, 399) == 0) begin
                fetch_en = en;
                do_reset();
            end
            step(en, rdy, br, tgt);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
